// File: rtl/ident_8b_uart_top.sv
// UART byte loopback for iCE40: receive one 8N1 byte, pass it through an
// identity datapath, transmit it back, then re-arm with clear-to-send low.
module ident_8b_uart_top #(
  parameter int ClocksPerBaud = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic tx_out,
  output logic clear_to_send_out_n
);

  localparam int CntW = $clog2(ClocksPerBaud);
  localparam logic [CntW-1:0] FullCount = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] HalfCount = CntW'(ClocksPerBaud / 2 - 1);
  localparam logic [CntW-1:0] CountOne  = CntW'(1);

  typedef enum logic [1:0] {
    ST_RECEIVE,
    ST_COMPUTE,
    ST_TRANSMIT
  } top_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  top_state_t top_state, top_next;
  rx_state_t  rx_state, rx_next;
  tx_state_t  tx_state, tx_next;

  logic            rx_meta;
  logic            rx_sync;
  logic [CntW-1:0] rx_count;
  logic [2:0]      rx_bit_cnt;
  logic [7:0]      rx_shift;
  logic            rx_await_high;
  logic            rx_armed;
  logic            rx_done;
  logic            rx_frame_err;

  logic [7:0]      held_byte;
  logic [7:0]      compute_result;

  logic [CntW-1:0] tx_count;
  logic [2:0]      tx_bit_cnt;
  logic [7:0]      tx_shift;
  logic            tx_reg;
  logic            tx_load;
  logic            tx_done;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  // ---------------- Top-level FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      top_state <= ST_RECEIVE;
    end else begin
      top_state <= top_next;
    end
  end

  always_comb begin
    top_next = top_state;
    case (top_state)
      ST_RECEIVE:  if (rx_done) top_next = ST_COMPUTE;
      ST_COMPUTE:  top_next = ST_TRANSMIT;
      ST_TRANSMIT: if (tx_done) top_next = ST_RECEIVE;
      default:     top_next = ST_RECEIVE;
    endcase
  end

  always_comb begin
    clear_to_send_out_n = 1'b1;
    rx_armed            = 1'b0;
    tx_load             = 1'b0;
    case (top_state)
      ST_RECEIVE: begin
        clear_to_send_out_n = 1'b0;
        rx_armed            = 1'b1;
      end
      ST_COMPUTE: tx_load = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_byte <= 8'h00;
    end else if (top_state == ST_RECEIVE && rx_done) begin
      held_byte <= rx_shift;
    end
  end

  // The datapath is the identity function on all eight bits.
  assign compute_result = held_byte;

  // ---------------- Receiver ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    if (!rx_armed) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:  if (!rx_sync && !rx_await_high) rx_next = RX_START;
        RX_START: if (rx_count == '0) rx_next = rx_sync ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_count == '0 && rx_bit_cnt == 3'd7) rx_next = RX_STOP;
        RX_STOP:  if (rx_count == '0) rx_next = RX_IDLE;
        default:  rx_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_done      = 1'b0;
    rx_frame_err = 1'b0;
    if (rx_armed && rx_state == RX_STOP && rx_count == '0) begin
      rx_done      = rx_sync;
      rx_frame_err = !rx_sync;
    end
  end

  // After a framing error the line is still low; ignore it until it idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count      <= '0;
      rx_bit_cnt    <= '0;
      rx_shift      <= '0;
      rx_await_high <= 1'b0;
    end else begin
      if (rx_frame_err) begin
        rx_await_high <= 1'b1;
      end else if (rx_sync) begin
        rx_await_high <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          rx_count   <= HalfCount;
          rx_bit_cnt <= '0;
        end
        RX_START: begin
          if (rx_count != '0) begin
            rx_count <= rx_count - CountOne;
          end else begin
            rx_count <= FullCount;
          end
        end
        RX_DATA: begin
          if (rx_count != '0) begin
            rx_count <= rx_count - CountOne;
          end else begin
            rx_count   <= FullCount;
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            rx_bit_cnt <= rx_bit_cnt + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_count != '0) begin
            rx_count <= rx_count - CountOne;
          end
        end
        default: rx_count <= HalfCount;
      endcase
    end
  end

  // ---------------- Transmitter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: if (tx_count == '0) tx_next = TX_DATA;
      TX_DATA:  if (tx_count == '0 && tx_bit_cnt == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_count == '0) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  assign tx_done = (tx_state == TX_STOP) && (tx_count == '0);

  // tx_reg always holds the level of the bit currently on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_reg     <= 1'b1;
      tx_count   <= '0;
      tx_bit_cnt <= '0;
      tx_shift   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_count   <= FullCount;
          tx_bit_cnt <= '0;
          if (tx_load) begin
            tx_shift <= compute_result;
            tx_reg   <= 1'b0;
          end else begin
            tx_reg <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_count != '0) begin
            tx_count <= tx_count - CountOne;
          end else begin
            tx_count <= FullCount;
            tx_reg   <= tx_shift[0];
          end
        end
        TX_DATA: begin
          if (tx_count != '0) begin
            tx_count <= tx_count - CountOne;
          end else begin
            tx_count   <= FullCount;
            tx_bit_cnt <= tx_bit_cnt + 3'd1;
            if (tx_bit_cnt == 3'd7) begin
              tx_reg <= 1'b1;
            end else begin
              tx_reg   <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end
        end
        TX_STOP: begin
          if (tx_count != '0) begin
            tx_count <= tx_count - CountOne;
          end else begin
            tx_reg <= 1'b1;
          end
        end
        default: tx_reg <= 1'b1;
      endcase
    end
  end

  assign tx_out = tx_reg;

endmodule

// File: tb/tb_ident_8b_uart_top.sv
// Bench for the UART identity loopback: a tx frame monitor pops expected
// bytes from a scoreboard queue filled as rx frames are driven.
module tb_ident_8b_uart_top;

  localparam int CPB      = 8;
  localparam int FrameLen = 10 * CPB;

  logic clk;
  logic rst;
  logic rx_in;
  logic tx_out;
  logic clear_to_send_out_n;

  int checks;
  int errors;
  logic [7:0] exp_q[$];

  ident_8b_uart_top #(.ClocksPerBaud(CPB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_in               (rx_in),
    .tx_out              (tx_out),
    .clear_to_send_out_n (clear_to_send_out_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are read just after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push);
    if (push) exp_q.push_back(b);
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) tick();
    end
    rx_in = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic wait_echo(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && clear_to_send_out_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Captures each tx frame cycle by cycle; a reset abandons a partial frame.
  task automatic run_monitor();
    logic [FrameLen-1:0] frame_bits;
    logic [7:0] got;
    logic [7:0] exp;
    logic centre;
    bit active;
    bit shape_ok;
    int idx;
    active = 1'b0;
    idx = 0;
    frame_bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx_out === 1'b0) begin
          active = 1'b1;
          frame_bits[0] = 1'b0;
          idx = 1;
        end
      end else begin
        frame_bits[idx] = tx_out;
        idx++;
        if (idx == FrameLen) begin
          active = 1'b0;
          shape_ok = 1'b1;
          got = 8'h00;
          for (int k = 0; k < 10; k++) begin
            centre = frame_bits[k*CPB + CPB/2];
            for (int j = 0; j < CPB; j++)
              if (frame_bits[k*CPB + j] !== centre) shape_ok = 1'b0;
            if (k >= 1 && k <= 8) got[k-1] = centre;
          end
          if (frame_bits[CPB/2] !== 1'b0 || frame_bits[9*CPB + CPB/2] !== 1'b1)
            shape_ok = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_unexpected_frame: got byte 0x%02h, required no frame", got);
          end else begin
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
              errors++;
              $display("[TB] FAIL tx_byte: got 0x%02h, required 0x%02h", got, exp);
            end
            checks++;
            if (!shape_ok) begin
              errors++;
              $display("[TB] FAIL tx_frame_shape: got bits %b, required start 0, stop 1, each bit %0d cycles",
                       frame_bits, CPB);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    bit idle_ok;
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (tx_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_tx_out: got %b, required 1", tx_out);
    end
    checks++;
    if (clear_to_send_out_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cts_n: got %b, required 0", clear_to_send_out_n);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx_out !== 1'b1 || clear_to_send_out_n !== 1'b0) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("[TB] FAIL reset_idle_hold: got activity on tx_out/cts_n, required tx_out=1 cts_n=0");
    end
  endtask

  task automatic test_basic();
    int tx_low_at;
    logic cts_before;
    logic cts_after;
    bit cts_hi_ok;
    tx_low_at = -1;
    cts_before = 1'bx;
    cts_after = 1'bx;
    cts_hi_ok = 1'b1;
    fork
      send_byte(8'h55, 1'b1);
      begin
        for (int i = 1; i <= 200; i++) begin
          tick();
          if (tx_out === 1'b0 && tx_low_at < 0) tx_low_at = i;
          if (i == 78) cts_before = clear_to_send_out_n;
          if (i >= 79 && i <= 159 && clear_to_send_out_n !== 1'b1) cts_hi_ok = 1'b0;
          if (i == 160) cts_after = clear_to_send_out_n;
        end
      end
    join
    checks++;
    if (tx_low_at != 80) begin
      errors++;
      $display("[TB] FAIL basic_latency: got tx start at cycle %0d, required 80", tx_low_at);
    end
    checks++;
    if (cts_before !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_cts_receive: got %b, required 0", cts_before);
    end
    checks++;
    if (!cts_hi_ok) begin
      errors++;
      $display("[TB] FAIL basic_cts_busy: got cts_n=0 during compute/transmit, required 1");
    end
    checks++;
    if (cts_after !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_cts_rearm: got %b, required 0", cts_after);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] seq [4];
    bit ok;
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01};
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i], 1'b1);
      wait_echo(40 * CPB, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL seq_echo_%0d: got no echo of 0x%02h, required echo within budget", i, seq[i]);
      end
    end
  endtask

  task automatic test_glitch();
    bit quiet_ok;
    rx_in = 1'b0;
    repeat (2) tick();
    rx_in = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 20 * CPB; i++) begin
      tick();
      if (tx_out !== 1'b1 || clear_to_send_out_n !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (!quiet_ok) begin
      errors++;
      $display("[TB] FAIL glitch_quiet: got activity on tx_out/cts_n, required tx_out=1 cts_n=0");
    end
  endtask

  task automatic test_framing_error();
    logic [7:0] b;
    bit quiet_ok;
    bit ok;
    b = 8'h3C;
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) tick();
    end
    rx_in = 1'b0;
    repeat (2 * CPB) tick();
    rx_in = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 0; i < 25 * CPB; i++) begin
      tick();
      if (tx_out !== 1'b1 || clear_to_send_out_n !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (!quiet_ok) begin
      errors++;
      $display("[TB] FAIL framing_no_tx: got activity on tx_out/cts_n, required none");
    end
    send_byte(8'h3C, 1'b1);
    wait_echo(40 * CPB, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL framing_recover_echo: got no echo of 0x3c, required echo");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit ok;
    bit seen;
    b = 8'h81;
    rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx_in = b[i];
      repeat (CPB) tick();
    end
    rst = 1'b1;
    rx_in = 1'b1;
    tick();
    checks++;
    if (tx_out !== 1'b1 || clear_to_send_out_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_rx: got tx_out=%b cts_n=%b, required tx_out=1 cts_n=0",
               tx_out, clear_to_send_out_n);
    end
    rst = 1'b0;
    repeat (3 * CPB) tick();
    send_byte(8'h81, 1'b1);
    wait_echo(40 * CPB, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rst_mid_rx_echo: got no echo of 0x81, required echo");
    end

    send_byte(8'h5A, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (tx_out === 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL rst_mid_tx_start: got no tx start bit, required one");
    end
    repeat (3 * CPB) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (tx_out !== 1'b1 || clear_to_send_out_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_tx: got tx_out=%b cts_n=%b, required tx_out=1 cts_n=0",
               tx_out, clear_to_send_out_n);
    end
    rst = 1'b0;
    repeat (3 * CPB) tick();
    send_byte(8'h81, 1'b1);
    wait_echo(40 * CPB, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rst_mid_tx_echo: got no echo of 0x81, required echo");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rx_in = 1'b1;
    fork
      run_monitor();
    join_none
    test_reset();
    test_basic();
    test_sequence();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    repeat (4 * CPB) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
